// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared datapath through
// fetch, decode, execute, memory and writeback, with a mem_req/mem_ready
// handshake toward a variable-latency unified memory.
module multicycle_ctrl #(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       Less,
    input  logic       LessU,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUctrl,
    output logic [2:0] funct3_o,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR_ADR, JALR_J, LUI, AUIPC
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001,
                           ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
                           ALU_XOR  = 4'b0100, ALU_SLL  = 4'b0101,
                           ALU_SRL  = 4'b0110, ALU_SRA  = 4'b0111,
                           ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001,
                           ALU_PASSB = 4'b1010;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                           OP_BR   = 7'b1100011, OP_JAL   = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111,
                           OP_AUIPC = 7'b0010111;

    state_t state_q, state_d;

    // funct3 -> ALU op; sub only exists for register-register ops
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic f7_5,
                                              input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state and output decode; rst forces every output low combinationally
    // so an in-flight memory access is dropped in the same cycle.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ImmSrc    = 3'b000;
        ALUctrl   = ILLEGAL_CTRL;
        funct3_o  = funct3;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUctrl   = ALU_ADD;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // precompute branch/jump target into ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUctrl = ALU_ADD;
                ImmSrc  = (op == OP_JAL) ? 3'b101 : 3'b011;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:     state_d = EXECR;
                    OP_I:     state_d = EXECI;
                    OP_BR:    state_d = BRANCH;
                    OP_JAL:   state_d = JAL;
                    OP_JALR:  state_d = JALR_ADR;
                    OP_LUI:   state_d = LUI;
                    OP_AUIPC: state_d = AUIPC;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUctrl = ALU_ADD;
                ImmSrc  = (op == OP_STORE) ? 3'b010 : 3'b000;
                state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUctrl = alu_decode(funct3, funct7_5, 1'b1);
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUctrl = alu_decode(funct3, funct7_5, 1'b0);
                ImmSrc  = (funct3 == 3'b001 || funct3 == 3'b101 ||
                           funct3 == 3'b011) ? 3'b001 : 3'b000;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUctrl = ALU_SUB;
                retire  = 1'b1;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    3'b100:  PCWrite = Less;
                    3'b101:  PCWrite = ~Less;
                    3'b110:  PCWrite = LessU;
                    3'b111:  PCWrite = ~LessU;
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b0;
                    end
                endcase
                state_d = FETCH;
            end
            JAL, JALR_J: begin
                // PC <= ALUOut (target); ALU computes OldPC+4 for rd
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUctrl = ALU_ADD;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            JALR_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUctrl = ALU_ADD;
                state_d = JALR_J;
            end
            LUI: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                ALUctrl = ALU_PASSB;
                state_d = ALUWB;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                ALUctrl = ALU_ADD;
                state_d = ALUWB;
            end
            default: state_d = FETCH;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ResultSrc = 2'b00;
            ImmSrc    = 3'b000;
            ALUctrl   = 4'b0000;
            funct3_o  = 3'b000;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-by-cycle vector table of
// inputs and hand-computed outputs, plus an async-reset-during-store sequence.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5, Zero, Less, LessU, mem_ready;
    logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc, funct3_o;
    logic [3:0] ALUctrl;
    logic       retire, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ILLEGAL_CTRL(4'b1111)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .Less(Less), .LessU(LessU), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .funct3_o(funct3_o),
        .retire(retire), .illegal(illegal)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, z, l, lu, rdy;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,A,B,ResultSrc,Imm,ALU,retire,illegal}
    function automatic logic [20:0] o(input logic mreq, adr, mw, irw, pcw, rw,
                                      input logic [1:0] a, b, rs,
                                      input logic [2:0] imm,
                                      input logic [3:0] alu,
                                      input logic ret, ill);
        return {mreq, adr, mw, irw, pcw, rw, a, b, rs, imm, alu, ret, ill};
    endfunction

    function automatic logic [20:0] act();
        return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl, retire, illegal};
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [20:0] a, input logic [20:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, a, e);
        end
    endtask

    task automatic add(input logic [6:0] op_i, input logic [2:0] f3,
                       input logic f7, z, l, lu, rdy, input logic [20:0] e);
        vec_t v;
        v.op = op_i; v.f3 = f3; v.f7 = f7; v.z = z; v.l = l; v.lu = lu;
        v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input int idx);
        op = v.op; funct3 = v.f3; funct7_5 = v.f7; Zero = v.z; Less = v.l;
        LessU = v.lu; mem_ready = v.rdy;
        #2;
        chk("outs", idx, act(), v.exp);
        chk("funct3_o", idx, {18'd0, funct3_o}, {18'd0, v.f3});
        @(posedge clk);
        #1;
    endtask

    logic [20:0] F_RDY, F_WAIT, DEC, DEC_J, DEC_ILL, WB, MRD, MWR;

    initial begin
        F_RDY   = o(1,0,0,1,1,0, 2'd0,2'd2,2'd2, 3'd0, 4'h0, 0,0);
        F_WAIT  = o(1,0,0,0,0,0, 2'd0,2'd2,2'd2, 3'd0, 4'h0, 0,0);
        DEC     = o(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd3, 4'h0, 0,0);
        DEC_J   = o(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd5, 4'h0, 0,0);
        DEC_ILL = o(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd3, 4'h0, 0,1);
        WB      = o(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0, 4'hF, 1,0);
        MRD     = o(1,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'hF, 0,0);
        MWR     = o(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'hF, 0,0);

        // add x3,x1,x2
        add(7'b0110011, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b0110011, 3'b000, 0,0,0,0,0, DEC);
        add(7'b0110011, 3'b000, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0, 4'h0, 0,0));
        add(7'b0110011, 3'b000, 0,0,0,0,0, WB);
        // sub
        add(7'b0110011, 3'b000, 1,0,0,0,1, F_RDY);
        add(7'b0110011, 3'b000, 1,0,0,0,0, DEC);
        add(7'b0110011, 3'b000, 1,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0, 4'h1, 0,0));
        add(7'b0110011, 3'b000, 1,0,0,0,0, WB);
        // lw, memory stalls 3 cycles; mem_ready in DECODE/MEMADR is ignored
        add(7'b0000011, 3'b010, 0,0,0,0,1, F_RDY);
        add(7'b0000011, 3'b010, 0,0,0,0,1, DEC);
        add(7'b0000011, 3'b010, 0,0,0,0,1, o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0, 4'h0, 0,0));
        add(7'b0000011, 3'b010, 0,0,0,0,0, MRD);
        add(7'b0000011, 3'b010, 0,0,0,0,0, MRD);
        add(7'b0000011, 3'b010, 0,0,0,0,0, MRD);
        add(7'b0000011, 3'b010, 0,0,0,0,1, MRD);
        add(7'b0000011, 3'b010, 0,0,0,0,0, o(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 3'd0, 4'hF, 1,0));
        // sw with one fetch stall and one store stall
        add(7'b0100011, 3'b010, 0,0,0,0,0, F_WAIT);
        add(7'b0100011, 3'b010, 0,0,0,0,1, F_RDY);
        add(7'b0100011, 3'b010, 0,0,0,0,0, DEC);
        add(7'b0100011, 3'b010, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd2, 4'h0, 0,0));
        add(7'b0100011, 3'b010, 0,0,0,0,0, MWR);
        add(7'b0100011, 3'b010, 0,0,0,0,1, o(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 4'hF, 1,0));
        // beq taken / not taken, bgeu taken, bne not taken, funct3=010 illegal
        add(7'b1100011, 3'b000, 0,1,0,0,1, F_RDY);
        add(7'b1100011, 3'b000, 0,1,0,0,0, DEC);
        add(7'b1100011, 3'b000, 0,1,0,0,0, o(0,0,0,0,1,0, 2'd2,2'd0,2'd0, 3'd0, 4'h1, 1,0));
        add(7'b1100011, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b1100011, 3'b000, 0,0,0,0,0, DEC);
        add(7'b1100011, 3'b000, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0, 4'h1, 1,0));
        add(7'b1100011, 3'b111, 0,0,0,0,1, F_RDY);
        add(7'b1100011, 3'b111, 0,0,0,0,0, DEC);
        add(7'b1100011, 3'b111, 0,0,0,0,0, o(0,0,0,0,1,0, 2'd2,2'd0,2'd0, 3'd0, 4'h1, 1,0));
        add(7'b1100011, 3'b001, 0,1,0,0,1, F_RDY);
        add(7'b1100011, 3'b001, 0,1,0,0,0, DEC);
        add(7'b1100011, 3'b001, 0,1,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0, 4'h1, 1,0));
        add(7'b1100011, 3'b010, 0,1,1,1,1, F_RDY);
        add(7'b1100011, 3'b010, 0,1,1,1,0, DEC);
        add(7'b1100011, 3'b010, 0,1,1,1,0, o(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0, 4'h1, 0,1));
        // jal
        add(7'b1101111, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b1101111, 3'b000, 0,0,0,0,0, DEC_J);
        add(7'b1101111, 3'b000, 0,0,0,0,0, o(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 3'd0, 4'h0, 0,0));
        add(7'b1101111, 3'b000, 0,0,0,0,0, WB);
        // jalr
        add(7'b1100111, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b1100111, 3'b000, 0,0,0,0,0, DEC);
        add(7'b1100111, 3'b000, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0, 4'h0, 0,0));
        add(7'b1100111, 3'b000, 0,0,0,0,0, o(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 3'd0, 4'h0, 0,0));
        add(7'b1100111, 3'b000, 0,0,0,0,0, WB);
        // lui, auipc
        add(7'b0110111, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b0110111, 3'b000, 0,0,0,0,0, DEC);
        add(7'b0110111, 3'b000, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd0,2'd1,2'd0, 3'd4, 4'hA, 0,0));
        add(7'b0110111, 3'b000, 0,0,0,0,0, WB);
        add(7'b0010111, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b0010111, 3'b000, 0,0,0,0,0, DEC);
        add(7'b0010111, 3'b000, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd4, 4'h0, 0,0));
        add(7'b0010111, 3'b000, 0,0,0,0,0, WB);
        // srai, addi with funct7_5=1 (still add), sltiu
        add(7'b0010011, 3'b101, 1,0,0,0,1, F_RDY);
        add(7'b0010011, 3'b101, 1,0,0,0,0, DEC);
        add(7'b0010011, 3'b101, 1,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd1, 4'h7, 0,0));
        add(7'b0010011, 3'b101, 1,0,0,0,0, WB);
        add(7'b0010011, 3'b000, 1,0,0,0,1, F_RDY);
        add(7'b0010011, 3'b000, 1,0,0,0,0, DEC);
        add(7'b0010011, 3'b000, 1,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0, 4'h0, 0,0));
        add(7'b0010011, 3'b000, 1,0,0,0,0, WB);
        add(7'b0010011, 3'b011, 0,0,0,0,1, F_RDY);
        add(7'b0010011, 3'b011, 0,0,0,0,0, DEC);
        add(7'b0010011, 3'b011, 0,0,0,0,0, o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd1, 4'h9, 0,0));
        add(7'b0010011, 3'b011, 0,0,0,0,0, WB);
        // undecodable opcode: illegal pulse in DECODE, straight back to FETCH
        add(7'b1111111, 3'b000, 0,0,0,0,1, F_RDY);
        add(7'b1111111, 3'b000, 0,0,0,0,0, DEC_ILL);
        add(7'b1111111, 3'b000, 0,0,0,0,0, F_WAIT);

        // reset state
        rst = 1'b1; op = 7'b0110011; funct3 = 3'b101; funct7_5 = 1'b1;
        Zero = 1'b1; Less = 1'b1; LessU = 1'b1; mem_ready = 1'b1;
        #12;
        chk("reset_outs", 0, act(), 21'd0);
        chk("reset_funct3_o", 0, {18'd0, funct3_o}, 21'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // sw stalled in MEMWRITE, then async reset mid-cycle
        begin
            vec_t v;
            v.op = 7'b0100011; v.f3 = 3'b010; v.f7 = 0; v.z = 0; v.l = 0; v.lu = 0;
            v.rdy = 1; v.exp = F_RDY; step(v, 100);
            v.rdy = 0; v.exp = DEC;   step(v, 101);
            v.exp = o(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd2, 4'h0, 0,0); step(v, 102);
            op = v.op; funct3 = v.f3; mem_ready = 1'b0;
            #2;
            chk("memwrite_wait", 103, act(), MWR);
            rst = 1'b1;
            #1;
            chk("rst_mem_req", 104, {20'd0, mem_req}, 21'd0);
            chk("rst_memwrite", 105, {20'd0, MemWrite}, 21'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            v.rdy = 0; v.exp = F_WAIT; step(v, 106);
            v.rdy = 1; v.exp = F_RDY;  step(v, 107);
            v.rdy = 0; v.exp = DEC;    step(v, 108);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It replaces the single-cycle CU decode with a sequenced controller that steps the shared datapath through fetch, decode, execute, memory and writeback. The datapath contains one ALU, one unified instruction/data memory port, and the IR, OldPC, ALUOut and Data registers. The block sits between the instruction register fields and datapath enables, and handshakes with variable-latency memory through mem_req/mem_ready.

Parameters:
ILLEGAL_CTRL, 4'b1111, ALUctrl value driven when no valid ALU operation applies.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
op  input  7  IR[6:0].
funct3  input  3  IR[14:12].
funct7_5  input  1  IR[30].
Zero  input  1  ALU result == 0.
Less  input  1  rs1 < rs2, signed.
LessU  input  1  rs1 < rs2, unsigned.
mem_ready  input  1  memory completes the current access this cycle.
mem_req  output  1  memory access request.
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
MemWrite  output  1  store enable.
IRWrite  output  1  load IR and OldPC.
PCWrite  output  1  PC <= Result.
RegWrite  output  1  register file write.
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
ResultSrc  output  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ImmSrc  output  3  immediate format: 000 = I, 001 = I-shamt/unsigned, 010 = S, 011 = B, 100 = U, 101 = J.
ALUctrl  output  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu, 1010 passB.
funct3_o  output  3  funct3 forwarded to the load/store unit.
retire  output  1  one-cycle pulse when an instruction completes.
illegal  output  1  one-cycle pulse when an opcode is undecodable.

Behaviour:
- Reset: clk and rst as named; reset is asynchronous and active-high. While rst=1, state=FETCH and every output is 0. After deassertion, the first edge starts FETCH.
- Outputs are Moore outputs decoded from state, except FETCH/MEMREAD/MEMWRITE enables, which are gated by mem_ready, and PCWrite in BRANCH. Unlisted outputs are 0; ALUctrl defaults to ILLEGAL_CTRL.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_ADR, JALR_J, LUI, AUIPC.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - If mem_ready: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise stay, with IRWrite=PCWrite=0.
- DECODE: ALUSrcA=01, ALUSrcB=01, add; ImmSrc=101 if op==1101111, else 011 (ALUOut <= target). Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> FETCH with illegal=1 and no retire.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=010 for stores, else 000. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1, go to FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. On mem_ready: retire=1, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. funct3 selects ALUctrl:
  - 000: add, or sub if funct7_5=1
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: srl, or sra if funct7_5=1
  - 110: or
  - 111: and
  - Then go to ALUWB.
- EXECI: same ALUctrl mapping as EXECR, except funct3=000 is always add. ALUSrcA=10, ALUSrcB=01. ImmSrc=001 for funct3 001/101/011, else 000. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1, go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite by funct3:
  - 000: Zero
  - 001: ~Zero
  - 100: Less
  - 101: ~Less
  - 110: LessU
  - 111: ~LessU
  - 010/011: 0 with illegal=1.
  - retire=1 (not on illegal), go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, go to ALUWB (rd <= OldPC+4).
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add, go to JALR_J.
- JALR_J: same as JAL. The datapath clears bit 0.
- LUI: ALUSrcB=01, ImmSrc=100, passB, go to ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100, add, go to ALUWB.
- funct3_o = funct3 in all states.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- rst mid-wait aborts the access; mem_req drops the same cycle.

Test Plan:
- Reset release, add x3,x1,x2 (funct7_5=0), mem_ready=1 in FETCH -> FETCH, DECODE, EXECR(ALUctrl=0000), ALUWB(RegWrite=1, retire=1), FETCH: 4 cycles.
- lw with mem_ready held 0 for 3 cycles in MEMREAD -> mem_req=1, AdrSrc=1 held. MEMWB follows the cycle after mem_ready=1. Total 5+3 cycles.
- sw -> MEMADR ImmSrc=010. MemWrite=1 only in MEMWRITE, with no RegWrite anywhere.
- beq with Zero=1, then Zero=0 -> PCWrite=1 vs 0 in BRANCH. bgeu with LessU=0 -> PCWrite=1.
- jalr -> JALR_ADR, JALR_J(PCWrite=1), ALUWB(RegWrite=1). op=7'b1111111 -> illegal pulse in DECODE, returns to FETCH, retire=0.
- rst=1 asynchronously during MEMWRITE wait -> MemWrite and mem_req go to 0 immediately. After release the FSM is in FETCH.
